// File: rtl/gears_pkg.sv
// Shared constants and the FSM state type for the ASCII decimal transmitter.
// Build option: ASCII_DEC_TX_NEWLINE_EN adds the EOL state that appends a
// line feed after the least significant digit.
package gears_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NL   = 8'h0A;

`ifdef ASCII_DEC_TX_NEWLINE_EN
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_EMIT    = 2'd2,
    ST_EOL     = 2'd3
  } tx_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_EMIT    = 2'd2
  } tx_state_e;
`endif

endpackage

// File: rtl/ascii_dec_tx_if.sv
// Handshake bundle for ascii_dec_tx.
//   in_valid/in_ready/in_value     : binary value input (producer -> block)
//   out_valid/out_ready/out_data   : ASCII byte stream (block -> consumer)
//   out_last                       : final byte of the current number
//   busy                           : block is not idle
// Modports: master = the side that feeds values and consumes bytes,
//           slave  = the transmitter itself.
interface ascii_dec_tx_if #(
  parameter int VAL_WIDTH = 64
);
  logic                 in_valid;
  logic                 in_ready;
  logic [VAL_WIDTH-1:0] in_value;
  logic                 out_valid;
  logic                 out_ready;
  logic [7:0]           out_data;
  logic                 out_last;
  logic                 busy;

  modport master (
    output in_valid, in_value, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );

  modport slave (
    input  in_valid, in_value, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/dd_digit_adj.sv
// Double-dabble correction for one BCD digit: a digit of 5 or more gets 3
// added so that the following left shift carries correctly into the next
// decade.
//   digit_i : current BCD digit
//   digit_o : corrected digit, ready to be shifted
module dd_digit_adj (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/ascii_dec_tx.sv
// Converts an unsigned binary value to decimal with a serial double-dabble
// (one bit per cycle, MSB first) and streams the digits as ASCII bytes,
// most significant non-zero digit first.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : ascii_dec_tx_if.slave (value input, byte output, busy)
// Build option: ASCII_DEC_TX_NEWLINE_EN appends 8'h0A after the last digit
// and moves out_last onto that line feed.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for a value, in_ready high
// CONVERT | shift-add-3 iterations, then pick the leading digit
// EMIT    | presenting digit[ptr] as ASCII until accepted
// EOL     | presenting the trailing line feed (newline build only)
module ascii_dec_tx
  import gears_pkg::*;
#(
  parameter int VAL_WIDTH = 64,
  parameter int DIGITS    = 20
) (
  input  logic          clk,
  input  logic          reset,
  ascii_dec_tx_if.slave bus
);

  localparam int BCD_W = DIGITS * 4;
  localparam int CNT_W = $clog2(VAL_WIDTH + 1);
  localparam int PTR_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  tx_state_e            state_q, state_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic [VAL_WIDTH-1:0] shf_q, shf_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;

  logic [BCD_W-1:0]     adj;
  logic [3:0]           cur_digit;
  logic [PTR_W-1:0]     msd_idx;
  logic                 unused_adj_msb;

  logic                 in_ready;
  logic                 out_valid;
  logic [7:0]           out_data;
  logic                 out_last;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    dd_digit_adj u_adj (
      .digit_i (bcd_q[g*4 +: 4]),
      .digit_o (adj[g*4 +: 4])
    );
  end

  // The top BCD bit is shifted out; with enough digits it is always zero.
  assign unused_adj_msb = adj[BCD_W-1];

  // Index of the most significant non-zero digit, 0 when the value is zero.
  always_comb begin
    msd_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[i*4 +: 4] != 4'd0) msd_idx = PTR_W'(i);
    end
  end

  always_comb begin
    cur_digit = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (PTR_W'(i) == ptr_q) cur_digit = bcd_q[i*4 +: 4];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      bcd_q   <= '0;
      shf_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      shf_q   <= shf_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bcd_d     = bcd_q;
    shf_d     = shf_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = 8'h00;
    out_last  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          shf_d   = bus.in_value;
          bcd_d   = '0;
          cnt_d   = CNT_W'(VAL_WIDTH);
          state_d = ST_CONVERT;
        end
      end

      // Counter reaching zero costs one extra cycle, used to register the
      // leading-digit pointer from the finished BCD value.
      ST_CONVERT: begin
        if (cnt_q != '0) begin
          {bcd_d, shf_d} = {adj[BCD_W-2:0], shf_q, 1'b0};
          cnt_d          = cnt_q - 1'b1;
        end else begin
          ptr_d   = msd_idx;
          state_d = ST_EMIT;
        end
      end

      ST_EMIT: begin
        out_valid = 1'b1;
        out_data  = ASCII_ZERO + {4'h0, cur_digit};
`ifdef ASCII_DEC_TX_NEWLINE_EN
        out_last  = 1'b0;
`else
        out_last  = (ptr_q == '0);
`endif
        if (bus.out_ready) begin
          if (ptr_q == '0) begin
`ifdef ASCII_DEC_TX_NEWLINE_EN
            state_d = ST_EOL;
`else
            state_d = ST_IDLE;
`endif
          end else begin
            ptr_d = ptr_q - 1'b1;
          end
        end
      end

`ifdef ASCII_DEC_TX_NEWLINE_EN
      ST_EOL: begin
        out_valid = 1'b1;
        out_data  = ASCII_NL;
        out_last  = 1'b1;
        if (bus.out_ready) state_d = ST_IDLE;
      end
`endif

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_last  = out_last;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ascii_dec_tx.sv
// Testbench for ascii_dec_tx: randomized and directed values, expected ASCII
// bytes from a divide-by-ten reference model pushed into a queue and checked
// by an independent monitor on the falling edge.
module tb_ascii_dec_tx;
  import gears_pkg::*;

  localparam int VW  = 64;
  localparam int LAT = VW + 1;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  ascii_dec_tx_if #(.VAL_WIDTH(VW)) bus ();

  ascii_dec_tx #(.VAL_WIDTH(VW), .DIGITS(20)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   vecs = 0;
  int   errs = 0;
  int   cyc = 0;
  int   pops = 0;
  int   rdy_mode = 0;
  int   acc_edge = 0;
  int   last_hs_edge = 0;
  logic wait_first = 1'b0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_last = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Reference model: decimal digits by repeated division, MSD first.
  function automatic void push_expected(input logic [63:0] v);
    logic [7:0] digs[$];
    logic [63:0] t;
    exp_t x;
    t = v;
    do begin
      digs.push_front(8'h30 + 8'(t % 64'd10));
      t = t / 64'd10;
    end while (t != 64'd0);
    for (int i = 0; i < digs.size(); i++) begin
      x.data = digs[i];
`ifdef ASCII_DEC_TX_NEWLINE_EN
      x.last = 1'b0;
`else
      x.last = (i == digs.size() - 1);
`endif
      exp_q.push_back(x);
    end
`ifdef ASCII_DEC_TX_NEWLINE_EN
    x.data = 8'h0A;
    x.last = 1'b1;
    exp_q.push_back(x);
`endif
  endfunction

  // out_ready driver
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        wait_first = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (wait_first && bus.out_valid) begin
          check("first_valid_latency", 64'(cyc - acc_edge), 64'(LAT));
          wait_first = 1'b0;
        end
        if (bus.in_valid && bus.in_ready) begin
          acc_edge   = cyc + 1;
          wait_first = 1'b1;
        end
        if (prev_stall) begin
          check("stall_valid", bus.out_valid, 1);
          check("stall_data", bus.out_data, prev_data);
          check("stall_last", bus.out_last, prev_last);
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            vecs++;
            errs++;
            $display("FAIL unexpected_byte: got %02h, expected none", bus.out_data);
          end else begin
            e = exp_q.pop_front();
            pops++;
            check("out_data", bus.out_data, e.data);
            check("out_last", bus.out_last, e.last);
            if (e.last) last_hs_edge = cyc + 1;
          end
        end
        prev_stall = bus.out_valid & ~bus.out_ready;
        prev_data  = bus.out_data;
        prev_last  = bus.out_last;
      end
    end
  end

  task automatic check_reset_outs(input string tag);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_data"},  bus.out_data, 0);
    check({tag, "_out_last"},  bus.out_last, 0);
    check({tag, "_busy"},      bus.busy, 0);
    check({tag, "_in_ready"},  bus.in_ready, 1);
  endtask

  // Presents v (in_valid left high) and returns the acceptance edge number.
  task automatic send(input logic [63:0] v, output int acc);
    push_expected(v);
    bus.in_value = v;
    bus.in_valid = 1'b1;
    acc = -1;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        acc = cyc;
        return;
      end
    end
    vecs++;
    errs++;
    $display("FAIL accept_timeout: got no in_ready, expected accept of %0d", v);
  endtask

  task automatic drain(input bit pulses);
    for (int n = 0; n < 6000; n++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && bus.in_ready) begin
        bus.in_valid = 1'b0;
        return;
      end
      if (pulses && exp_q.size() != 0) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_value = {$urandom, $urandom};
        check("in_ready_while_busy", bus.in_ready, 0);
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    vecs++;
    errs++;
    $display("FAIL drain_timeout: got %0d bytes pending, expected 0", exp_q.size());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int a, a7, a42, p0;
    logic [63:0] v;
    bus.in_valid = 1'b0;
    bus.in_value = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outs("rst");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    rdy_mode = 0;
    send(64'd0, a);
    bus.in_valid = 1'b0;
    drain(0);

    send(64'd467835, a);
    bus.in_valid = 1'b0;
    drain(0);

    send(64'hFFFF_FFFF_FFFF_FFFF, a);
    bus.in_valid = 1'b0;
    drain(0);

    rdy_mode = 1;
    send(64'd1024, a);
    bus.in_valid = 1'b0;
    drain(1);

    // Reset while the second digit of 9876 is on the bus.
    rdy_mode = 0;
    p0 = pops;
    send(64'd9876, a);
    bus.in_valid = 1'b0;
    for (int n = 0; n < 200 && pops < p0 + 1; n++) begin
      @(posedge clk);
      #1;
    end
    #1;
    check("mid_emit_valid", bus.out_valid, 1);
    check("mid_emit_data", bus.out_data, 8'h38);
    reset = 1'b1;
    #1;
    check_reset_outs("async_rst");
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outs("post_rst");
    send(64'd5, a);
    bus.in_valid = 1'b0;
    drain(0);

    // Back-to-back with in_valid held.
    send(64'd7, a7);
    send(64'd42, a42);
    bus.in_valid = 1'b0;
    check("b2b_accept_gap", 64'(a42 - last_hs_edge), 64'd1);
    drain(0);

    for (int k = 0; k < 10; k++) begin
      rdy_mode = int'($urandom_range(0, 1));
      v = {$urandom, $urandom} >> $urandom_range(0, 63);
      send(v, a);
      bus.in_valid = 1'b0;
      drain(1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
